rs_enc_param: RTL and testbench

Parametrised systematic Reed-Solomon encoder over GF(2^SW) with a streaming valid/ready interface. It generalises the fixed 16-stage RS(255,239) parity-LFSR chain. Parity count, symbol width, field polynomial, first consecutive root and maximum message length are all parameters. It adds backpressure, runtime-shortened frames via `in_last`, and in-band parity emission. It sits between the framer and the interleaver; the codeword is the message symbols passed through unchanged, followed by NPAR parity symbols.

---
 rtl/rs_pkg.sv | 65 ++++++
 rtl/rs_par_stage.sv | 41 ++++
 rtl/rs_enc_param.sv | 130 +++++++++++++
 tb/tb_rs_enc_param.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// ============================================================================
//  Module      : rs_pkg
//  Description : GF(2^SW) arithmetic helpers and shared types for the
//                parametrised Reed-Solomon encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_pkg;

    localparam int MAX_NPAR = 64;

    typedef logic [MAX_NPAR-1:0][15:0] coef_vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Shift-and-add multiply; the result stays below 2^sw for inputs below 2^sw.
    function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b,
                                           input int sw, input int unsigned poly);
        int unsigned p;
        int unsigned x;
        p = 0;
        x = a;
        for (int i = 0; i < 16; i++) begin
            if (i < sw) begin
                if (b[i]) p = p ^ x;
                x = x << 1;
                if (x[sw]) x = x ^ poly;
            end
        end
        return p;
    endfunction

    function automatic int unsigned gf_pow(input int e, input int sw, input int unsigned poly);
        int unsigned r;
        r = 1;
        for (int i = 0; i < e; i++) r = gf_mul(r, 2, sw, poly);
        return r;
    endfunction

    // Expands prod(x + alpha^(fcr+i)); entry j is the coefficient of x^j.
    function automatic coef_vec_t gen_poly(input int npar, input int fcr, input int sw,
                                           input int unsigned poly);
        logic [MAX_NPAR:0][15:0] g;
        int unsigned root;
        coef_vec_t res;
        g    = '0;
        g[0] = 16'd1;
        for (int i = 0; i < npar; i++) begin
            root = gf_pow(fcr + i, sw, poly);
            for (int j = i + 1; j > 0; j--)
                g[j] = g[j-1] ^ 16'(gf_mul(32'(g[j]), root, sw, poly));
            g[0] = 16'(gf_mul(32'(g[0]), root, sw, poly));
        end
        for (int j = 0; j < MAX_NPAR; j++) res[j] = g[j];
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_par_stage.sv
// ============================================================================
//  Module      : rs_par_stage
//  Description : One parity register of the RS division LFSR with its
//                constant generator-coefficient multiply.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_par_stage
    import rs_pkg::*;
#(
    parameter int          SW        = 8,
    parameter int unsigned PRIM_POLY = 'h11D,
    parameter int unsigned COEF      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] fb,
    input  logic [SW-1:0] prev,
    input  logic          shift_en,
    input  logic          fb_en,
    output logic [SW-1:0] par
);

    logic [SW-1:0] prod;

    always_comb begin
        prod = fb_en ? SW'(gf_mul(32'(fb), COEF, SW, PRIM_POLY)) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par <= '0;
        end else if (shift_en) begin
            par <= prev ^ prod;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_enc_param.sv
// ============================================================================
//  Module      : rs_enc_param
//  Description : Streaming systematic RS encoder: passes message symbols
//                through, then appends NPAR parity symbols in-band.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_enc_param
    import rs_pkg::*;
#(
    parameter int          SW        = 8,
    parameter int unsigned PRIM_POLY = 'h11D,
    parameter int          FCR       = 0,
    parameter int          NPAR      = 16,
    parameter int          KMAX      = 239
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_data,
    output logic          out_last,
    output logic          out_par,
    output logic          err_len
);

    localparam int              MCW      = $clog2(KMAX + 1);
    localparam int              PCW      = $clog2(NPAR + 1);
    localparam coef_vec_t       GEN      = gen_poly(NPAR, FCR, SW, PRIM_POLY);
    localparam logic [MCW-1:0]  MSG_LAST = MCW'(KMAX - 1);
    localparam logic [PCW-1:0]  PAR_LAST = PCW'(NPAR - 1);

    state_t          state;
    logic [MCW-1:0]  msg_cnt;
    logic [PCW-1:0]  par_cnt;
    logic [SW-1:0]   r [0:NPAR-1];
    logic [SW-1:0]   fb;
    logic            load;
    logic            accept;
    logic            last_sym;
    logic            par_emit;
    logic            shift_en;

    always_comb begin
        load     = !out_valid || out_ready;
        in_ready = (state != PARITY) && load;
        accept   = in_valid && in_ready;
        last_sym = in_last || (msg_cnt == MSG_LAST);
        par_emit = (state == PARITY) && load;
        shift_en = accept || par_emit;
        fb       = in_data ^ r[NPAR-1];
    end

    // Feedback is gated off while draining, so the chain becomes a plain shift.
    generate
        for (genvar i = 0; i < NPAR; i++) begin : g_stage
            logic [SW-1:0] prev;
            if (i == 0) begin : g_first
                assign prev = '0;
            end else begin : g_chain
                assign prev = r[i-1];
            end
            rs_par_stage #(
                .SW        (SW),
                .PRIM_POLY (PRIM_POLY),
                .COEF      (32'(GEN[i]))
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .fb       (fb),
                .prev     (prev),
                .shift_en (shift_en),
                .fb_en    (accept),
                .par      (r[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            msg_cnt   <= '0;
            par_cnt   <= '0;
            err_len   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_par   <= 1'b0;
        end else begin
            err_len <= accept && !in_last && (msg_cnt == MSG_LAST);
            if (accept) begin
                msg_cnt <= last_sym ? '0 : msg_cnt + 1'b1;
                state   <= last_sym ? PARITY : DATA;
            end
            if (par_emit) begin
                if (par_cnt == PAR_LAST) begin
                    par_cnt <= '0;
                    state   <= IDLE;
                end else begin
                    par_cnt <= par_cnt + 1'b1;
                end
            end
            if (load) begin
                if (accept) begin
                    out_valid <= 1'b1;
                    out_data  <= in_data;
                    out_par   <= 1'b0;
                    out_last  <= 1'b0;
                end else if (par_emit) begin
                    out_valid <= 1'b1;
                    out_data  <= r[NPAR-1];
                    out_par   <= 1'b1;
                    out_last  <= (par_cnt == PAR_LAST);
                end else begin
                    out_valid <= 1'b0;
                    out_par   <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_enc_param.sv
// ============================================================================
//  Module      : tb_rs_enc_param
//  Description : Directed self-checking bench for rs_enc_param (default
//                RS(255,239) instance and a GF(16) NPAR=4 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rs_enc_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [7:0] in_data;

    logic       in_ready_a, out_valid_a, out_last_a, out_par_a, err_len_a;
    logic [7:0] out_data_a;
    logic       in_ready_b, out_valid_b, out_last_b, out_par_b, err_len_b;
    logic [3:0] out_data_b;

    rs_enc_param dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a),
        .out_par(out_par_a), .err_len(err_len_a)
    );

    rs_enc_param #(.SW(4), .PRIM_POLY('h13), .FCR(0), .NPAR(4), .KMAX(11)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready_b),
        .in_data(in_data[3:0]), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b),
        .out_par(out_par_b), .err_len(err_len_b)
    );

    wire       ov = sel ? out_valid_b : out_valid_a;
    wire       ol = sel ? out_last_b  : out_last_a;
    wire       op = sel ? out_par_b   : out_par_a;
    wire       el = sel ? err_len_b   : err_len_a;
    wire [7:0] od = sel ? {4'h0, out_data_b} : out_data_a;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference GF(256) arithmetic via log/antilog tables.
    int unsigned gexp [0:509];
    int unsigned glog [0:255];
    int unsigned g    [0:16];

    function automatic int unsigned gm(input int unsigned a, input int unsigned b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    logic [9:0] expq [$];
    logic [9:0] gotq [$];
    logic [7:0] msg  [0:254];
    int         stall_pct = 0;
    int         err_cnt   = 0;
    int         ir_low    = 0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
        end
    end

    // Output collector plus hold-while-stalled check.
    initial begin
        logic       hold_v;
        logic [9:0] hold;
        hold_v = 1'b0;
        hold   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst && el) err_cnt++;
            if (rst && !sel && !in_ready_a) ir_low++;
            if (hold_v && rst) check("stall_hold", {21'd0, ov, ol, op, od}, {21'd0, 1'b1, hold});
            hold_v = ov && !out_ready && rst;
            hold   = {ol, op, od};
            if (ov && out_ready && rst) gotq.push_back({ol, op, od});
        end
    end

    task automatic send(input int k, input bit use_last);
        int idx;
        int guard;
        logic fire;
        idx   = 0;
        guard = 0;
        while (idx < k && guard < 5000) begin
            @(negedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = msg[idx];
            in_last  = use_last && (idx == k - 1);
            #1;
            fire = sel ? in_ready_b : in_ready_a;
            @(posedge clk);
            if (fire) idx++;
            guard++;
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_accepted", idx, k);
    endtask

    task automatic push_a(input int k);
        int unsigned r [0:15];
        int unsigned fb;
        for (int j = 0; j < 16; j++) r[j] = 0;
        for (int i = 0; i < k; i++) begin
            expq.push_back({2'b00, msg[i]});
            fb = msg[i] ^ r[15];
            for (int j = 15; j > 0; j--) r[j] = r[j-1] ^ gm(g[j], fb);
            r[0] = gm(g[0], fb);
        end
        for (int j = 0; j < 16; j++) expq.push_back({(j == 15), 1'b1, 8'(r[15-j])});
    endtask

    task automatic pb(input logic l, input logic p, input logic [7:0] d);
        expq.push_back({l, p, d});
    endtask

    task automatic finish_frame(input string tag);
        int guard;
        guard = 0;
        while (gotq.size() < expq.size() && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        repeat (4) @(posedge clk);
        check({tag, "_len"}, gotq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) check(tag, gotq[i], expq[i]);
    endtask

    task automatic clear_q();
        expq.delete();
        gotq.delete();
        err_cnt = 0;
        ir_low  = 0;
    endtask

    initial begin
        int unsigned x;
        int unsigned s;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i]       = x;
            gexp[i + 255] = x;
            glog[x]       = i;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11D;
        end
        for (int j = 0; j <= 16; j++) g[j] = 0;
        g[0] = 1;
        for (int i = 0; i < 16; i++) begin
            for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gm(g[j], gexp[i]);
            g[0] = gm(g[0], gexp[i]);
        end

        rst = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        #1;
        check("rst_out_valid", out_valid_a, 0);
        check("rst_in_ready",  in_ready_a,  1);
        check("rst_out_data",  out_data_a,  0);
        check("rst_last_par",  {out_last_a, out_par_a}, 0);
        check("rst_err_len",   err_len_a,   0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_q();

        // All-zero full frame: zero parity, out_last on beat 255 only.
        for (int i = 0; i < 255; i++) msg[i] = 8'h00;
        send(239, 1'b1);
        push_a(239);
        finish_frame("zero_frame");
        check("zero_last_beat", gotq.size() > 0 ? gotq[gotq.size()-1] : 10'h0, 10'h300);
        check("zero_ready_low", ir_low, 16);
        clear_q();

        // x^16 * 1 mod g: parity equals g15..g0.
        msg[238] = 8'h01;
        send(239, 1'b1);
        for (int i = 0; i < 239; i++) pb(1'b0, 1'b0, msg[i]);
        for (int j = 0; j < 16; j++) pb(j == 15, 1'b1, 8'(g[15-j]));
        finish_frame("unit_frame");
        clear_q();

        // Shortened K=1 frame of 'hFF.
        msg[0] = 8'hFF;
        send(1, 1'b1);
        pb(1'b0, 1'b0, 8'hFF);
        for (int j = 0; j < 16; j++) pb(j == 15, 1'b1, 8'(gm(g[15-j], 'hFF)));
        finish_frame("k1_frame");
        check("k1_ready_low", ir_low, 16);
        clear_q();

        // Random frame without and with output stalls, plus zero syndrome.
        for (int i = 0; i < 239; i++) msg[i] = 8'($urandom_range(0, 255));
        send(239, 1'b1);
        push_a(239);
        finish_frame("rand_frame");
        clear_q();
        stall_pct = 50;
        send(239, 1'b1);
        push_a(239);
        finish_frame("rand_stall");
        for (int i = 0; i < 16; i++) begin
            s = 0;
            foreach (gotq[n]) s = gm(s, gexp[i]) ^ 32'(gotq[n][7:0]);
            check("syndrome", s, 0);
        end
        clear_q();
        stall_pct = 0;

        // KMAX symbols without in_last: one-cycle err_len, then parity.
        send(239, 1'b0);
        push_a(239);
        finish_frame("kmax_frame");
        check("kmax_err_pulses", err_cnt, 1);
        clear_q();

        // Asynchronous reset mid-frame, then a clean frame.
        send(50, 1'b0);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_a, 0);
        check("midrst_in_ready",  in_ready_a,  1);
        check("midrst_out_data",  out_data_a,  0);
        check("midrst_last_par",  {out_last_a, out_par_a, err_len_a}, 0);
        @(negedge clk);
        rst = 1'b1;
        clear_q();
        send(239, 1'b1);
        push_a(239);
        finish_frame("post_rst_frame");
        clear_q();

        // GF(16), g = x^4 + 15x^3 + 3x^2 + x + 12, hand-derived parity.
        sel = 1'b1;
        msg[0] = 8'h01;
        send(1, 1'b1);
        pb(0, 0, 1); pb(0, 1, 15); pb(0, 1, 3); pb(0, 1, 1); pb(1, 1, 12);
        finish_frame("s_k1_one");
        clear_q();
        msg[0] = 8'h02;
        send(1, 1'b1);
        pb(0, 0, 2); pb(0, 1, 13); pb(0, 1, 6); pb(0, 1, 2); pb(1, 1, 11);
        finish_frame("s_k1_two");
        clear_q();
        stall_pct = 50;
        msg[0] = 8'h01; msg[1] = 8'h00;
        send(2, 1'b1);
        pb(0, 0, 1); pb(0, 0, 0); pb(0, 1, 9); pb(0, 1, 3); pb(0, 1, 3); pb(1, 1, 8);
        finish_frame("s_k2");
        clear_q();
        stall_pct = 0;
        for (int i = 0; i < 11; i++) msg[i] = 8'h00;
        send(11, 1'b0);
        for (int i = 0; i < 11; i++) pb(0, 0, 0);
        pb(0, 1, 0); pb(0, 1, 0); pb(0, 1, 0); pb(1, 1, 0);
        finish_frame("s_kmax");
        check("s_kmax_err_pulses", err_cnt, 1);
        clear_q();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
